// File: rtl/oflow_reg_sched_pkg.sv
// Shared types for the oflow registration score-board scheduler.
// State encoding and channel-index width helper.
package oflow_reg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oflow_reg_sched_popcount.sv
// Combinational popcount of simultaneous score-board completions.
module oflow_reg_sched_popcount #(
    parameter int N = 2,
    parameter int W = 5
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/oflow_registration_sb_scheduler.sv
// Round-robin dispatch of per-set start pulses to NUM_SB score-board
// engines, gated by score-calc tokens, with completion and timeout tracking.
module oflow_registration_sb_scheduler
    import oflow_reg_sched_pkg::*;
#(
    parameter int SET_LEN = 5,
    parameter int FRAME_W = 12,
    parameter int NUM_SB  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic [FRAME_W-1:0] frame_num,
    input  logic [SET_LEN-1:0] num_of_sets,
    input  logic               start_registration,
    input  logic               abort,
    input  logic               done_score_calc,
    input  logic [NUM_SB-1:0]  done_score_board,
    output logic [NUM_SB-1:0]  start_score_board,
    output logic [SET_LEN-1:0] sb_set_idx,
    output logic [SET_LEN-1:0] issued_sets,
    output logic [SET_LEN-1:0] completed_sets,
    output logic               busy,
    output logic               done_registration,
    output logic               timeout_err
);

    localparam int CW = ch_w(NUM_SB);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e             state;
    logic [SET_LEN-1:0] num;
    logic [SET_LEN-1:0] pending;
    logic               ff_mode;
    logic [NUM_SB-1:0]  ch_busy;
    logic [CW-1:0]      ch_ptr;
    logic [TW-1:0]      tmo;

    logic [NUM_SB-1:0]  qual;
    logic [NUM_SB-1:0]  sel;
    logic [NUM_SB-1:0]  busy_nxt;
    logic [SET_LEN-1:0] comp_cnt;
    logic [SET_LEN-1:0] issued_nxt;
    logic [SET_LEN-1:0] completed_nxt;
    logic [SET_LEN-1:0] pending_nxt;
    logic [CW-1:0]      ptr_nxt;
    logic               tok;
    logic               do_issue;
    logic               active;
    logic               activity;
    logic               tmo_hit;

    oflow_reg_sched_popcount #(
        .N (NUM_SB),
        .W (SET_LEN)
    ) u_popcount (
        .bits  (qual),
        .count (comp_cnt)
    );

    always_comb begin
        qual     = done_score_board & ch_busy;
        sel      = NUM_SB'(1) << ch_ptr;
        tok      = ff_mode || (pending != '0) || done_score_calc;
        // dispatch stalls on a busy engine instead of skipping it
        do_issue = (state == ST_RUN) && (issued_sets < num)
                 && !ch_busy[ch_ptr] && tok && !abort;
        active   = (state == ST_RUN) || (state == ST_DRAIN);
        activity = do_issue || (qual != '0);
        tmo_hit  = active && !activity
                 && (tmo == TW'(TIMEOUT - 1));

        issued_nxt    = issued_sets + SET_LEN'(do_issue);
        completed_nxt = completed_sets + comp_cnt;
        busy_nxt      = (ch_busy & ~qual) | (do_issue ? sel : '0);
        ptr_nxt       = (ch_ptr == CW'(NUM_SB - 1))
                      ? '0 : ch_ptr + CW'(1);

        pending_nxt = pending;
        if (!ff_mode) begin
            if (done_score_calc && !do_issue && (pending < num))
                pending_nxt = pending + SET_LEN'(1);
            else if (!done_score_calc && do_issue)
                pending_nxt = pending - SET_LEN'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state             <= ST_IDLE;
            num               <= '0;
            pending           <= '0;
            ff_mode           <= 1'b0;
            ch_busy           <= '0;
            ch_ptr            <= '0;
            tmo               <= '0;
            start_score_board <= '0;
            sb_set_idx        <= '0;
            issued_sets       <= '0;
            completed_sets    <= '0;
            busy              <= 1'b0;
            done_registration <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            start_score_board <= '0;
            done_registration <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                ch_busy <= '0;
                tmo     <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_registration) begin
                            if (num_of_sets == '0) begin
                                done_registration <= 1'b1;
                            end else begin
                                num            <= num_of_sets;
                                ff_mode        <= (frame_num == '0);
                                issued_sets    <= '0;
                                completed_sets <= '0;
                                pending        <= SET_LEN'(
                                    (frame_num != '0) && done_score_calc);
                                ch_busy        <= '0;
                                timeout_err    <= 1'b0;
                                tmo            <= '0;
                                busy           <= 1'b1;
                                state          <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN, ST_DRAIN: begin
                        if (do_issue) begin
                            start_score_board <= sel;
                            sb_set_idx        <= issued_sets;
                            ch_ptr            <= ptr_nxt;
                        end
                        issued_sets    <= issued_nxt;
                        completed_sets <= completed_nxt;
                        pending        <= pending_nxt;
                        ch_busy        <= busy_nxt;
                        if (tmo_hit) begin
                            timeout_err <= 1'b1;
                            ch_busy     <= '0;
                            busy        <= 1'b0;
                            tmo         <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            tmo <= activity ? '0 : tmo + TW'(1);
                            if (state == ST_RUN && issued_nxt == num) begin
                                state <= ST_DRAIN;
                            end else if (state == ST_DRAIN
                                         && completed_nxt == num) begin
                                state             <= ST_DONE;
                                busy              <= 1'b0;
                                done_registration <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
